// File: rtl/mycpu_pkg.sv
// Shared types and defaults for the 16-bit mycpu datapath.
package mycpu_pkg;

   localparam int unsigned DEF_REG_N = 8;
   localparam int unsigned DEF_DW    = 16;

   typedef logic [2:0] reg_addr_t;

   typedef enum logic [0:0] {
      MD_FU  = 1'b0,
      MD_MEM = 1'b1
   } md_t;

   typedef enum logic [0:0] {
      MB_REG   = 1'b0,
      MB_CONST = 1'b1
   } mb_t;

   typedef enum logic [3:0] {
      FMOVA = 4'd0,
      FINC  = 4'd1,
      FADD  = 4'd2,
      FSUB  = 4'd5,
      FDEC  = 4'd6,
      FAND  = 4'd8,
      FOR   = 4'd9,
      FXOR  = 4'd10,
      FNOT  = 4'd11,
      FMOVB = 4'd12,
      FSHR  = 4'd13,
      FSHL  = 4'd14
   } fs_t;

endpackage

// File: rtl/regfile_status_reg.sv
// Status register: zero/negative flags with a shared load enable.
module status_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic we_i,
   input  logic z_i,
   input  logic n_i,
   output logic z_o,
   output logic n_o
);

   logic z_q, z_d;
   logic n_q, n_d;

   always_comb begin
      z_d = z_q;
      n_d = n_q;
      if (we_i) begin
         z_d = z_i;
         n_d = n_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q <= 1'b0;
         n_q <= 1'b0;
      end else begin
         z_q <= z_d;
         n_q <= n_d;
      end
   end

   assign z_o = z_q;
   assign n_o = n_q;

endmodule

// File: rtl/regfile.sv
// Architectural register file with two combinational read ports, a constant
// select on the B bus, FU/memory write-back and the status register.
module regfile
   import mycpu_pkg::*;
#(
   parameter int unsigned REG_N = DEF_REG_N,
   parameter int unsigned DW    = DEF_DW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(REG_N)-1:0] aa,
   input  logic [$clog2(REG_N)-1:0] ba,
   input  logic [$clog2(REG_N)-1:0] da,
   input  logic                     rw,
   input  logic                     md,
   input  logic                     mb,
   input  logic [DW-1:0]            f_in,
   input  logic [DW-1:0]            mem_in,
   input  logic [DW-1:0]            const_in,
   input  logic                     z_in,
   input  logic                     n_in,
   input  logic                     fl_we,
   output logic [DW-1:0]            a_out,
   output logic [DW-1:0]            b_out,
   output logic                     z_flag,
   output logic                     n_flag
);

   logic [DW-1:0] regs_q [REG_N];
   logic [DW-1:0] regs_d [REG_N];
   logic [DW-1:0] wd;

   assign wd = (md_t'(md) == MD_MEM) ? mem_in : f_in;

   always_comb begin
      regs_d = regs_q;
      if (rw) begin
         regs_d[da] = wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight from the array: a bypass would form a loop through the FU.
   assign a_out = regs_q[aa];
   assign b_out = (mb_t'(mb) == MB_CONST) ? const_in : regs_q[ba];

   status_reg u_status (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (fl_we),
      .z_i   (z_in),
      .n_i   (n_in),
      .z_o   (z_flag),
      .n_o   (n_flag)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed and randomized checks of regfile against a plain-array reference model.
module tb_regfile;
   import mycpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  aa, ba, da;
   logic        rw, md, mb;
   logic [15:0] f_in, mem_in, const_in;
   logic        z_in, n_in, fl_we;
   logic [15:0] a_out, b_out;
   logic        z_flag, n_flag;

   logic [15:0] model [8];
   logic        mz, mn;
   int          n_vec = 0;
   int          n_err = 0;

   regfile #(.REG_N(8), .DW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .aa       (aa),
      .ba       (ba),
      .da       (da),
      .rw       (rw),
      .md       (md),
      .mb       (mb),
      .f_in     (f_in),
      .mem_in   (mem_in),
      .const_in (const_in),
      .z_in     (z_in),
      .n_in     (n_in),
      .fl_we    (fl_we),
      .a_out    (a_out),
      .b_out    (b_out),
      .z_flag   (z_flag),
      .n_flag   (n_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fu(input fs_t fs, input logic [15:0] a, input logic [15:0] b);
      case (fs)
         FMOVA:   return a;
         FINC:    return a + 16'd1;
         FADD:    return a + b;
         FSUB:    return a - b;
         FDEC:    return a - 16'd1;
         FAND:    return a & b;
         FOR:     return a | b;
         FXOR:    return a ^ b;
         FNOT:    return ~a;
         FMOVB:   return b;
         FSHR:    return a >> 1;
         FSHL:    return a << 1;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_a"}, a_out, model[aa]);
      check({tag, "_b"}, b_out, mb ? const_in : model[ba]);
      check({tag, "_z"}, {15'd0, z_flag}, {15'd0, mz});
      check({tag, "_n"}, {15'd0, n_flag}, {15'd0, mn});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      mz = 1'b0;
      mn = 1'b0;
   endtask

   // Update the model from the current inputs, then advance past the edge.
   task automatic tick();
      if (rw) model[da] = md ? mem_in : f_in;
      if (fl_we) begin
         mz = z_in;
         mn = n_in;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rw = 0; md = 0; mb = 0; fl_we = 0;
      f_in = '0; mem_in = '0; const_in = '0; z_in = 0; n_in = 0;
      aa = '0; ba = '0; da = '0;
   endtask

   initial begin
      logic [15:0] v;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #12;
      for (int i = 0; i < 8; i++) begin
         aa = 3'(i); ba = 3'(7 - i); #1;
         check("reset_rd", a_out, 16'h0000);
         check("reset_rdb", b_out, 16'h0000);
      end
      check("reset_z", {15'd0, z_flag}, 16'h0000);
      check("reset_n", {15'd0, n_flag}, 16'h0000);
      rst_n = 1'b1;

      // R3 <- 1234, no bypass in the write cycle
      da = 3'd3; aa = 3'd3; rw = 1; md = 0; f_in = 16'h1234; #1;
      check("r3_same_cycle", a_out, 16'h0000);
      tick();
      check("r3_after_a", a_out, 16'h1234);
      ba = 3'd3; mb = 0; #1;
      check("r3_after_b", b_out, 16'h1234);

      // R7 <- BEEF from memory, then a disabled write must not land
      da = 3'd7; md = 1; mem_in = 16'hBEEF; rw = 1;
      tick();
      rw = 0; md = 0; f_in = 16'h0000; aa = 3'd7;
      tick();
      check("r7_hold", a_out, 16'hBEEF);

      mb = 1; const_in = 16'h0005; ba = 3'd7; #1;
      check("b_const", b_out, 16'h0005);
      mb = 0; #1;
      check("b_reg", b_out, 16'hBEEF);

      // FINC loop through R1 for four edges
      aa = 3'd1; da = 3'd1; rw = 1; md = 0;
      for (int k = 0; k < 4; k++) begin
         f_in = fu(FINC, a_out, b_out);
         tick();
      end
      check("loop_r1", a_out, 16'h0004);
      check("loop_model", model[1], 16'h0004);
      rw = 0;

      v = fu(FINC, 16'h7FFF, 16'h0000);
      fl_we = 1; z_in = (v == 16'h0000); n_in = v[15];
      tick();
      fl_we = 0; z_in = 1; n_in = 0;
      tick();
      check("flag_n", {15'd0, n_flag}, 16'h0001);
      check("flag_z", {15'd0, z_flag}, 16'h0000);

      // Asynchronous reset between edges
      aa = 3'd3; ba = 3'd7; mb = 0; rw = 1; fl_we = 1; #1;
      check_all("pre_rst");
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_a", a_out, 16'h0000);
      check("arst_b", b_out, 16'h0000);
      check("arst_n", {15'd0, n_flag}, 16'h0000);
      idle_inputs();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic, including concurrent rw/fl_we and same-address read/write
      for (int k = 0; k < 300; k++) begin
         aa = 3'($urandom_range(0, 7));
         ba = 3'($urandom_range(0, 7));
         da = ($urandom_range(0, 3) == 0) ? aa : 3'($urandom_range(0, 7));
         rw = 1'($urandom_range(0, 1));
         md = 1'($urandom_range(0, 1));
         mb = 1'($urandom_range(0, 1));
         fl_we = 1'($urandom_range(0, 1));
         z_in = 1'($urandom_range(0, 1));
         n_in = 1'($urandom_range(0, 1));
         f_in = 16'($urandom);
         mem_in = 16'($urandom);
         const_in = 16'($urandom);
         #1;
         check_all("rand_pre");
         tick();
         check_all("rand_post");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
